nios_dbg_cmd_sysclk: RTL and testbench

- Next-generation system-clock half of the Nios II JTAG debug slave.
- Receives the scan register (sr) and instruction register (ir_in) from the TCK-domain shifter, plus toggle-encoded update-DR and update-IR events.
- Synchronises the events into clk and queues each update-DR frame in a small FIFO.
- Presents frames on a valid/ready interface and emits one-hot take_action / take_no_action pulses per IR channel, generalising the fixed 2-bit IR, 38-bit frame decode.

---
 rtl/nios_dbg_pkg.sv | 26 ++
 rtl/nios_dbg_toggle_sync.sv | 29 ++
 rtl/nios_dbg_cmd_sysclk.sv | 154 +++++++++++++++
 tb/tb_nios_dbg_cmd_sysclk.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the system-clock half of the Nios II JTAG debug slave:
// default geometry, IR channel encodings and the queued frame layout.
package nios_dbg_pkg;

    localparam int NIOS_IR_W = 2;
    localparam int NIOS_DW   = 38;
    localparam int ACT_BIT   = NIOS_DW - 1;

    typedef enum logic [NIOS_IR_W-1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_chan_e;

    typedef struct packed {
        logic [NIOS_IR_W-1:0] ir;
        logic [NIOS_DW-1:0]   data;
    } frame_t;

    // Action flag position for an arbitrary frame width.
    function automatic int act_bit(input int dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/nios_dbg_toggle_sync.sv
// Brings a TCK-domain toggle into clk through SYNC_STAGES flops and turns each
// transition into a single-cycle pulse by comparing against a history flop.
module nios_dbg_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tgl_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], tgl_i};
    assign hist_d  = sync_q[SYNC_STAGES-1];
    assign pulse_o = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/nios_dbg_cmd_sysclk.sv
// System-clock command side of the Nios II JTAG debug slave: synchronised
// update-DR frames are queued and handed out on valid/ready, each pop giving a
// one-hot take_action/take_no_action pulse. Define NIOS_DBG_CMD_PARITY_EN to
// drop frames whose sr[0] parity bit does not match sr[DW-1:1].
module nios_dbg_cmd_sysclk
    import nios_dbg_pkg::*;
#(
    parameter int IR_W        = NIOS_IR_W,
    parameter int DW          = NIOS_DW,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 udr_tgl,
    input  logic                 uir_tgl,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DW-1:0]        sr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [DW-1:0]        jdo,
    output logic [(1<<IR_W)-1:0] take_action,
    output logic [(1<<IR_W)-1:0] take_no_action,
    output logic                 uir_pulse,
    output logic                 overflow,
    output logic                 parity_err,
    input  logic                 clr_sticky
);

    localparam int NCH = 1 << IR_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int ACT = act_bit(DW);
    localparam int BW  = $clog2(SYNC_STAGES + 2);
    localparam logic [BW-1:0] BLANK = BW'(SYNC_STAGES + 1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DW-1:0]   data;
    } entry_t;

    logic udr_raw, uir_raw, udr_evt, uir_evt;

    nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .tgl_i   (udr_tgl),
        .pulse_o (udr_raw)
    );

    nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .tgl_i   (uir_tgl),
        .pulse_o (uir_raw)
    );

    logic [BW-1:0]  blank_q, blank_d;
    logic           cap_vld_q, cap_vld_d;
    entry_t         cap_q;
    entry_t         mem_q [FIFO_DEPTH];
    entry_t         head;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic           cmd_valid_q, cmd_valid_d;
    logic [NCH-1:0] ta_q, ta_d, tna_q, tna_d;
    logic           uir_pulse_q, uir_pulse_d;
    logic           overflow_q, overflow_d;
    logic           full, pop, wr_req, wr_en, ovf_set;

    // Synchroniser start-up (reset-time toggle levels) is hidden by the blanking counter.
    assign udr_evt = udr_raw & (blank_q == '0);
    assign uir_evt = uir_raw & (blank_q == '0);

`ifdef NIOS_DBG_CMD_PARITY_EN
    logic par_ok, par_set, parity_err_q, parity_err_d;
    assign par_ok       = (cap_q.data[0] == ~^cap_q.data[DW-1:1]);
    assign par_set      = cap_vld_q & ~par_ok;
    assign parity_err_d = par_set | (parity_err_q & ~clr_sticky);

    always_ff @(posedge clk) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end
    assign parity_err = parity_err_q;
`else
    logic par_ok;
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign count   = wptr_q - rptr_q;
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = cmd_valid_q & cmd_ready;
    assign wr_req  = cap_vld_q & par_ok;
    assign wr_en   = wr_req & (~full | pop);
    assign ovf_set = wr_req & full & ~pop;
    assign head    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        blank_d     = (blank_q != '0) ? blank_q - BW'(1) : blank_q;
        cap_vld_d   = udr_evt;
        wptr_d      = wptr_q + PW'(wr_en);
        rptr_d      = rptr_q + PW'(pop);
        // Frames written this cycle are presented one cycle later.
        cmd_valid_d = (count - PW'(pop)) != '0;
        ta_d        = '0;
        tna_d       = '0;
        if (pop) begin
            if (head.data[ACT]) ta_d  = NCH'(1) << head.ir;
            else                tna_d = NCH'(1) << head.ir;
        end
        uir_pulse_d = uir_evt;
        overflow_d  = ovf_set | (overflow_q & ~clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q     <= BLANK;
            cap_vld_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cmd_valid_q <= 1'b0;
            ta_q        <= '0;
            tna_q       <= '0;
            uir_pulse_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            blank_q     <= blank_d;
            cap_vld_q   <= cap_vld_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cmd_valid_q <= cmd_valid_d;
            ta_q        <= ta_d;
            tna_q       <= tna_d;
            uir_pulse_q <= uir_pulse_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (udr_evt) cap_q <= '{ir: ir_in, data: sr};
        if (wr_en)   mem_q[wptr_q[AW-1:0]] <= cap_q;
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_ir         = cmd_valid_q ? head.ir   : '0;
    assign jdo            = cmd_valid_q ? head.data : '0;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign uir_pulse      = uir_pulse_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk.sv
// Scoreboard bench for nios_dbg_cmd_sysclk: frames are queued as toggles are
// driven and checked, with their action pulses, as the DUT pops them.
module tb_nios_dbg_cmd_sysclk;
    import nios_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        udr_tgl = 1'b0;
    logic        uir_tgl = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        uir_pulse;
    logic        overflow;
    logic        parity_err;
    logic        clr_sticky = 1'b0;

    int passed = 0;
    int total  = 0;

    frame_t     sbq[$];
    logic [3:0] exp_ta  = '0;
    logic [3:0] exp_tna = '0;

    always #5 clk = ~clk;

    nios_dbg_cmd_sysclk dut (
        .clk            (clk),
        .reset          (reset),
        .udr_tgl        (udr_tgl),
        .uir_tgl        (uir_tgl),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .uir_pulse      (uir_pulse),
        .overflow       (overflow),
        .parity_err     (parity_err),
        .clr_sticky     (clr_sticky)
    );

    // Scoreboard monitor: pulses must follow exactly the pops observed one cycle earlier.
    always @(negedge clk) begin
        frame_t f;
        if (reset) begin
            exp_ta  = '0;
            exp_tna = '0;
        end else begin
            total++;
            if (take_action !== exp_ta || take_no_action !== exp_tna)
                $display("FAIL pulses: got ta=%b tna=%b, want ta=%b tna=%b at %0t",
                         take_action, take_no_action, exp_ta, exp_tna, $time);
            else passed++;
            exp_ta  = '0;
            exp_tna = '0;
            if (cmd_valid && cmd_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    $display("FAIL pop_unexpected: got ir=%0d jdo=%h, want no frame", cmd_ir, jdo);
                end else begin
                    f = sbq.pop_front();
                    if (cmd_ir !== f.ir || jdo !== f.data)
                        $display("FAIL pop_frame: got ir=%0d jdo=%h, want ir=%0d jdo=%h",
                                 cmd_ir, jdo, f.ir, f.data);
                    else passed++;
                    if (f.data[ACT_BIT]) exp_ta  = 4'b0001 << f.ir;
                    else                 exp_tna = 4'b0001 << f.ir;
                end
            end
        end
    end

    task automatic push_frame(input logic [1:0] ir, input logic [37:0] data);
        frame_t f;
        f.ir   = ir;
        f.data = data;
        sbq.push_back(f);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cmd_valid, take_action, take_no_action, uir_pulse, overflow, parity_err} !== '0 || jdo !== '0)
            $display("FAIL reset_outputs: got valid=%b ta=%b tna=%b uir=%b ovf=%b perr=%b jdo=%h, want all 0",
                     cmd_valid, take_action, take_no_action, uir_pulse, overflow, parity_err, jdo);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_single_action();
        cmd_ready = 1'b1;
        ir_in     = IR_TRACEMEM;
        sr        = 38'h20_0000_0005;
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0) $display("FAIL latency_early: got cmd_valid=%b, want 0", cmd_valid);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b1 || jdo !== 38'h20_0000_0005)
            $display("FAIL latency: got cmd_valid=%b jdo=%h, want 1 20_0000_0005", cmd_valid, jdo);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (take_action !== 4'b0010) $display("FAIL take_action: got %b, want 0010", take_action);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ir_in = 2'(i);
            sr    = 38'h20_0000_0100 + 38'(i);
            if (i < 4) push_frame(ir_in, sr);
            udr_tgl = ~udr_tgl;
            repeat (5) @(posedge clk); #1;
            if (i == 3) begin
                total++;
                if (overflow !== 1'b0) $display("FAIL ovf_at_full: got %b, want 0", overflow);
                else passed++;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (overflow !== 1'b1 || cmd_valid !== 1'b1 || jdo !== 38'h20_0000_0100 || cmd_ir !== 2'd0)
            $display("FAIL ovf_hold: got ovf=%b valid=%b ir=%0d jdo=%h, want 1 1 0 20_0000_0100",
                     overflow, cmd_valid, cmd_ir, jdo);
        else passed++;
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (cmd_valid !== (k < 4))
                $display("FAIL b2b_pop%0d: got cmd_valid=%b, want %b", k, cmd_valid, (k < 4));
            else passed++;
        end
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        total++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, want 0", overflow);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_no_action();
        bit seen = 0;
        cmd_ready = 1'b1;
        ir_in     = IR_TRACECTRL;
        sr        = 38'h00_0000_00AA;
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (take_no_action !== 4'b0000) seen = 1;
        end
        total++;
        if (!seen || take_no_action !== 4'b1000 || take_action !== 4'b0000)
            $display("FAIL no_action: got tna=%b ta=%b seen=%0d, want tna=1000 ta=0000",
                     take_no_action, take_action, seen);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_same_edge();
        int pulses = 0;
        cmd_ready = 1'b1;
        ir_in     = IR_BREAK;
        sr        = 38'h3F_FFFF_FFFF;
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        uir_tgl = ~uir_tgl;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (uir_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) $display("FAIL uir_once: got %0d pulses, want 1", pulses);
        else passed++;
        total++;
        if (sbq.size() != 0) $display("FAIL same_edge_drain: got %0d left, want 0", sbq.size());
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        cmd_ready = 1'b1;
        ir_in     = IR_OCIMEM;
        sr        = 38'h00_0000_0003;
`ifdef NIOS_DBG_CMD_PARITY_EN
        udr_tgl = ~udr_tgl;
        repeat (8) @(posedge clk);
        @(negedge clk);
        total++;
        if (parity_err !== 1'b1 || overflow !== 1'b0)
            $display("FAIL parity_bad: got perr=%b ovf=%b, want 1 0", parity_err, overflow);
        else passed++;
        @(posedge clk); #1;
        sr = 38'h00_0000_0002;
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        for (int c = 0; c < 12 && sbq.size() != 0; c++) @(negedge clk);
        total++;
        if (sbq.size() != 0) $display("FAIL parity_good: got %0d left, want 0", sbq.size());
        else passed++;
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        total++;
        if (parity_err !== 1'b0) $display("FAIL parity_clear: got %b, want 0", parity_err);
        else passed++;
`else
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        for (int c = 0; c < 12 && sbq.size() != 0; c++) @(negedge clk);
        total++;
        if (sbq.size() != 0 || parity_err !== 1'b0)
            $display("FAIL parity_off: got left=%0d perr=%b, want 0 0", sbq.size(), parity_err);
        else passed++;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_blanking();
        bit any = 0;
        cmd_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset   = 1'b0;
        ir_in   = IR_BREAK;
        sr      = 38'h20_0000_0BAD;
        udr_tgl = ~udr_tgl;
        uir_tgl = ~uir_tgl;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || uir_pulse !== 1'b0) any = 1;
        end
        total++;
        if (any) $display("FAIL blanking: got activity=1, want 0");
        else passed++;
        @(posedge clk); #1;
        sr = 38'h20_0000_0600;
        push_frame(ir_in, sr);
        udr_tgl = ~udr_tgl;
        for (int c = 0; c < 12 && sbq.size() != 0; c++) @(negedge clk);
        total++;
        if (sbq.size() != 0) $display("FAIL after_blank: got %0d left, want 0", sbq.size());
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ir_in   = 2'(i);
            sr      = 38'h20_0000_0700 + 38'(i);
            udr_tgl = ~udr_tgl;
            repeat (3) @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b1) $display("FAIL mid_pre: got cmd_valid=%b, want 1", cmd_valid);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset     = 1'b0;
        cmd_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL mid_reset: got valid=%b ovf=%b, want 0 0", cmd_valid, overflow);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_action();
        test_overflow();
        test_no_action();
        test_same_edge();
        test_parity();
        test_blanking();
        test_reset_mid();
        total++;
        if (sbq.size() != 0) $display("FAIL sb_empty: got %0d frames left, want 0", sbq.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
